// File: rtl/frame_scan_pkg.sv
// frame_scan_pkg
//   Shared definitions for the frame scan sequencer: the FSM state encoding
//   and helpers that derive the beat count and beat index width from the
//   frame geometry.
package frame_scan_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } scan_state_t;

    // Beats per frame: every beat carries pos_count pixels.
    function automatic int calc_beats(input int width, input int height, input int pos_count);
        return (width * height) / pos_count;
    endfunction

    // Index width for the beat counter, never narrower than one bit.
    function automatic int calc_beat_bits(input int beats);
        int w;
        w = $clog2(beats);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/frame_scan_sequencer.sv
// frame_scan_sequencer
//   Sequences the parallel-lane coordinate generator through one frame scan.
//   Resets the generator, presents one valid/ready beat per coordinate step
//   to the pixel pipeline, increments the generator on every accepted beat,
//   cross-checks the generator's finished flag against the beat count and
//   reports completion plus a running frame count.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start, abort    frame trigger (IDLE only) / abandon current frame
//   busy, done      not-IDLE flag / one-cycle frame-complete pulse
//   err             sticky finished-flag mismatch, cleared by rst or start
//   gen_rst/gen_inc generator reset and increment
//   gen_finished    generator all-lanes-wrapped flag
//   out_valid/ready beat handshake to the pixel pipeline
//   beat_idx        current beat index
//   frame_count     completed frames (wraps)
//
// Build option
//   FRAME_SCAN_SEQUENCER_CONTINUOUS_EN: FIN chains straight into CLEAR for a
//   free-running scan; abort still returns to IDLE.
module frame_scan_sequencer
    import frame_scan_pkg::*;
#(
    parameter int WIDTH          = 256,
    parameter int HEIGHT         = 256,
    parameter int POS_COUNT      = 4,
    parameter int FRAME_CNT_BITS = 16,
    localparam int BEATS         = calc_beats(WIDTH, HEIGHT, POS_COUNT),
    localparam int BEAT_BITS     = calc_beat_bits(BEATS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic                      gen_rst,
    output logic                      gen_inc,
    input  logic                      gen_finished,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [BEAT_BITS-1:0]      beat_idx,
    output logic [FRAME_CNT_BITS-1:0] frame_count
);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(BEATS - 1);

    scan_state_t               r_state;
    scan_state_t               w_state_nxt;
    logic [BEAT_BITS-1:0]      r_beat_idx;
    logic [FRAME_CNT_BITS-1:0] r_frame_count;
    logic                      r_err;
    logic                      w_handshake;
    logic                      w_last_beat;
    logic                      w_start_ok;

    assign w_handshake = (r_state == RUN) && out_ready;
    assign w_last_beat = (r_beat_idx == LAST_BEAT);
    // abort outranks start even when idle
    assign w_start_ok  = start && !abort;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_beat_idx    <= '0;
            r_frame_count <= '0;
            r_err         <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_start_ok) r_err <= 1'b0;
                end
                CLEAR: begin
                    r_beat_idx <= '0;
                end
                RUN: begin
                    // The generator only reports finished once the last
                    // increment has landed, so any earlier report is a fault.
                    if (gen_finished) r_err <= 1'b1;
                    if (w_handshake && !w_last_beat) r_beat_idx <= r_beat_idx + 1'b1;
                end
                CHECK: begin
                    if (!gen_finished) r_err <= 1'b1;
                end
                FIN: begin
                    r_frame_count <= r_frame_count + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_start_ok) w_state_nxt = CLEAR;
            CLEAR: w_state_nxt = abort ? IDLE : RUN;
            RUN: begin
                if (abort)                          w_state_nxt = IDLE;
                else if (w_handshake && w_last_beat) w_state_nxt = CHECK;
            end
            CHECK: w_state_nxt = abort ? IDLE : FIN;
`ifdef FRAME_SCAN_SEQUENCER_CONTINUOUS_EN
            FIN:   w_state_nxt = abort ? IDLE : CLEAR;
`else
            FIN:   w_state_nxt = IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign done        = (r_state == FIN);
    assign err         = r_err;
    // Generator is held in reset alongside the sequencer.
    assign gen_rst     = rst || (r_state == CLEAR);
    assign out_valid   = (r_state == RUN);
    assign gen_inc     = w_handshake;
    assign beat_idx    = r_beat_idx;
    assign frame_count = r_frame_count;

endmodule
